// File: rtl/result_display_ctrl.sv
// Voting-machine mode controller: vote-acknowledge hold window, iterative
// binary-to-BCD conversion of the selected candidate's count, seven-segment drive.
module result_display_ctrl #(
   parameter int NUM_CAND    = 4,
   parameter int VOTE_W      = 8,
   parameter int DIGITS      = 3,
   parameter int HOLD_CYCLES = 100000000,
   parameter int HOLD_W      = 27
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       mode,
   input  logic                       valid_vote_casted,
   input  logic [NUM_CAND*VOTE_W-1:0] votes,
   input  logic [NUM_CAND-1:0]        cand_button,
   output logic                       vote_ack,
   output logic [7:0]                 candidate,
   output logic [DIGITS*7-1:0]        seg,
   output logic                       busy
);

   function automatic int dec_digits(input int w);
      longint v;
      int     n;
      v = (longint'(1) << w) - 1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 10) begin
            v = v / 10;
            n = n + 1;
         end
      end
      return n;
   endfunction

   localparam int IDX_W   = $clog2(NUM_CAND);
   localparam int BCD_DIG = dec_digits(VOTE_W);
   localparam int PAD_DIG = (BCD_DIG > DIGITS) ? BCD_DIG : DIGITS;
   localparam int STEP_W  = $clog2(VOTE_W + 1);
   localparam int ACC_W   = BCD_DIG*4 + VOTE_W;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [6:0]        SEG_DASH  = 7'b0000001;

   typedef enum logic [1:0] {IDLE, CONVERT, DISPLAY} state_t;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // Any nonzero BCD digit beyond the displayed ones means value >= 10^DIGITS.
   function automatic logic [DIGITS*7-1:0] render(input logic [PAD_DIG*4-1:0] bcd);
      logic [DIGITS*7-1:0] out;
      logic                overflow;
      logic                leading;
      logic [3:0]          nib;
      out      = '0;
      overflow = (bcd >> (DIGITS*4)) != '0;
      leading  = 1'b1;
      for (int d = DIGITS-1; d >= 0; d--) begin
         nib = bcd[d*4 +: 4];
         if (nib != 4'd0) leading = 1'b0;
         if (overflow)               out[d*7 +: 7] = SEG_DASH;
         else if (leading && d != 0) out[d*7 +: 7] = 7'b0000000;
         else                        out[d*7 +: 7] = seg_code(nib);
      end
      return out;
   endfunction

   function automatic logic [ACC_W-1:0] dd_step(input logic [ACC_W-1:0] acc);
      logic [ACC_W-1:0] t;
      t = acc;
      for (int k = 0; k < BCD_DIG; k++) begin
         if (t[VOTE_W + k*4 +: 4] >= 4'd5) t[VOTE_W + k*4 +: 4] = t[VOTE_W + k*4 +: 4] + 4'd3;
      end
      return {t[ACC_W-2:0], 1'b0};
   endfunction

   function automatic logic [VOTE_W-1:0] pick(input logic [NUM_CAND*VOTE_W-1:0] v,
                                              input logic [IDX_W-1:0]           idx);
      logic [VOTE_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (idx == IDX_W'(i)) r = v[i*VOTE_W +: VOTE_W];
      end
      return r;
   endfunction

   state_t                state_q, state_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic                  ack_q, ack_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VOTE_W-1:0]     val_q, val_d;
   logic [BCD_DIG*4-1:0]  bcd_q, bcd_d;
   logic [VOTE_W-1:0]     bin_q, bin_d;
   logic [STEP_W-1:0]     step_q, step_d;
   logic                  busy_q, busy_d;
   logic [DIGITS*7-1:0]   seg_q, seg_d;
   logic [7:0]            cand_q, cand_d;

   logic                  req_valid;
   logic [IDX_W-1:0]      req_idx;
   logic                  start;

   // Lowest set button wins: scan downward so the last hit is the lowest index.
   always_comb begin
      req_valid = 1'b0;
      req_idx   = '0;
      for (int i = NUM_CAND-1; i >= 0; i--) begin
         if (cand_button[i]) begin
            req_valid = 1'b1;
            req_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      hold_d = hold_q;
      if (valid_vote_casted)    hold_d = HOLD_W'(1);
      else if (hold_q != '0)    hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + HOLD_W'(1);
      ack_d = (hold_d != '0);

      state_d = state_q;
      idx_d   = idx_q;
      val_d   = val_q;
      bcd_d   = bcd_q;
      bin_d   = bin_q;
      step_d  = step_q;
      busy_d  = busy_q;
      seg_d   = seg_q;
      cand_d  = cand_q;
      start   = 1'b0;

      if (!mode) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         seg_d   = '0;
         cand_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               seg_d  = '0;
               cand_d = '0;
               busy_d = 1'b0;
               if (req_valid) begin
                  idx_d = req_idx;
                  val_d = pick(votes, req_idx);
                  start = 1'b1;
               end
            end
            CONVERT: begin
               {bcd_d, bin_d} = dd_step({bcd_q, bin_q});
               step_d         = step_q + STEP_W'(1);
               if (step_q == STEP_W'(VOTE_W - 1)) begin
                  state_d = DISPLAY;
                  busy_d  = 1'b0;
               end
            end
            DISPLAY: begin
               seg_d  = render((PAD_DIG*4)'(bcd_q));
               cand_d = 8'd193 + 8'(idx_q);
               if (req_valid && req_idx != idx_q) begin
                  idx_d = req_idx;
                  val_d = pick(votes, req_idx);
                  start = 1'b1;
               end else if (pick(votes, idx_q) != val_q) begin
                  val_d = pick(votes, idx_q);
                  start = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (start) begin
            state_d = CONVERT;
            busy_d  = 1'b1;
            bin_d   = val_d;
            bcd_d   = '0;
            step_d  = '0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values of the others; blocking here would chain updates within one edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         ack_q   <= 1'b0;
         idx_q   <= '0;
         val_q   <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
         step_q  <= '0;
         busy_q  <= 1'b0;
         seg_q   <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         ack_q   <= ack_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
         seg_q   <= seg_d;
         cand_q  <= cand_d;
      end
   end

   assign vote_ack  = ack_q;
   assign candidate = cand_q;
   assign seg       = seg_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Directed bench for result_display_ctrl: a 3-digit and a 2-digit instance share
// stimulus; expected segment patterns are written out by hand.
module tb_result_display_ctrl;
   localparam int NUM_CAND = 4;
   localparam int VOTE_W   = 8;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                          S4 = 7'b0110011, S5 = 7'b1011011, S7 = 7'b1110000,
                          S9 = 7'b1111011, BL = 7'b0000000, DA = 7'b0000001;

   logic                       clock = 1'b0;
   logic                       reset;
   logic                       mode;
   logic                       valid_vote_casted;
   logic [NUM_CAND*VOTE_W-1:0] votes;
   logic [NUM_CAND-1:0]        cand_button;
   logic                       vote_ack, vote_ack2, busy, busy2;
   logic [7:0]                 candidate, candidate2;
   logic [20:0]                seg;
   logic [13:0]                seg2;

   int tests  = 0;
   int failed = 0;

   always #5 clock = ~clock;

   result_display_ctrl #(.NUM_CAND(NUM_CAND), .VOTE_W(VOTE_W), .DIGITS(3),
                         .HOLD_CYCLES(10), .HOLD_W(4)) dut (
      .clock(clock), .reset(reset), .mode(mode), .valid_vote_casted(valid_vote_casted),
      .votes(votes), .cand_button(cand_button), .vote_ack(vote_ack),
      .candidate(candidate), .seg(seg), .busy(busy));

   result_display_ctrl #(.NUM_CAND(NUM_CAND), .VOTE_W(VOTE_W), .DIGITS(2),
                         .HOLD_CYCLES(10), .HOLD_W(4)) dut2 (
      .clock(clock), .reset(reset), .mode(mode), .valid_vote_casted(valid_vote_casted),
      .votes(votes), .cand_button(cand_button), .vote_ack(vote_ack2),
      .candidate(candidate2), .seg(seg2), .busy(busy2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_vote(input int i, input logic [VOTE_W-1:0] v);
      votes[i*VOTE_W +: VOTE_W] = v;
   endtask

   task automatic wait_display();
      repeat (VOTE_W + 2) tick();
   endtask

   initial begin
      int n;
      reset             = 1'b1;
      mode              = 1'b0;
      valid_vote_casted = 1'b0;
      votes             = '0;
      cand_button       = '0;
      tick();
      tick();
      check("rst_ack", 32'(vote_ack), 0);
      check("rst_cand", 32'(candidate), 0);
      check("rst_seg", 32'(seg), 0);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b0;

      // Hold window: single pulse, then a restart mid-window
      valid_vote_casted = 1'b1;
      tick();
      valid_vote_casted = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (vote_ack) n++;
         tick();
      end
      check("ack_len", 32'(n), 9);
      valid_vote_casted = 1'b1;
      tick();
      valid_vote_casted = 1'b0;
      repeat (4) tick();
      check("ack_mid", 32'(vote_ack), 1);
      valid_vote_casted = 1'b1;
      tick();
      valid_vote_casted = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (vote_ack) n++;
         tick();
      end
      check("ack_restart_len", 32'(n), 9);

      // Result mode, candidate 0 = 7, with exact latency
      set_vote(0, 8'd7);
      set_vote(1, 8'd42);
      set_vote(2, 8'd205);
      set_vote(3, 8'd100);
      mode        = 1'b1;
      cand_button = 4'b0001;
      tick();
      check("busy_start", 32'(busy), 1);
      repeat (7) tick();
      check("busy_last", 32'(busy), 1);
      tick();
      check("busy_done", 32'(busy), 0);
      check("cand_not_yet", 32'(candidate), 0);
      tick();
      check("cand_c0", 32'(candidate), 193);
      check("seg_7", 32'(seg), 32'({BL, BL, S7}));
      check("seg2_7", 32'(seg2), 32'({BL, S7}));

      // Two buttons: lowest index wins
      cand_button = 4'b0110;
      wait_display();
      check("cand_c1", 32'(candidate), 194);
      check("seg_42", 32'(seg), 32'({BL, S4, S2}));
      check("seg2_42", 32'(seg2), 32'({S4, S2}));
      cand_button = 4'b0100;
      wait_display();
      check("cand_c2", 32'(candidate), 195);
      check("seg_205", 32'(seg), 32'({S2, S0, S5}));
      check("seg2_205_ovf", 32'(seg2), 32'({DA, DA}));

      // Overflow boundary on the 2-digit display
      cand_button = 4'b1000;
      wait_display();
      check("cand_c3", 32'(candidate), 196);
      check("seg_100", 32'(seg), 32'({S1, S0, S0}));
      check("seg2_100_ovf", 32'(seg2), 32'({DA, DA}));

      // Live count change re-triggers the conversion with the button held
      set_vote(3, 8'd9);
      wait_display();
      check("seg_9", 32'(seg), 32'({BL, BL, S9}));
      check("seg2_9", 32'(seg2), 32'({BL, S9}));
      set_vote(3, 8'd10);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (busy) n++;
      end
      check("busy_len_retrig", 32'(n), 8);
      check("seg_10", 32'(seg), 32'({BL, S1, S0}));
      check("seg2_10", 32'(seg2), 32'({S1, S0}));
      check("cand_c3_keep", 32'(candidate), 196);

      // Held button with unchanged value: no new conversion
      tick();
      check("busy_idle_hold", 32'(busy), 0);

      // mode drops during conversion
      set_vote(3, 8'd55);
      tick();
      check("busy_55", 32'(busy), 1);
      tick();
      tick();
      mode = 1'b0;
      tick();
      check("abort_busy", 32'(busy), 0);
      check("abort_seg", 32'(seg), 0);
      check("abort_cand", 32'(candidate), 0);
      mode = 1'b1;
      wait_display();
      check("seg_55", 32'(seg), 32'({BL, S5, S5}));
      check("cand_55", 32'(candidate), 196);

      // Reset in DISPLAY with an open hold window
      valid_vote_casted = 1'b1;
      tick();
      valid_vote_casted = 1'b0;
      tick();
      check("ack_before_rst", 32'(vote_ack), 1);
      reset = 1'b1;
      tick();
      check("rst2_ack", 32'(vote_ack), 0);
      check("rst2_cand", 32'(candidate), 0);
      check("rst2_seg", 32'(seg), 0);
      check("rst2_seg2", 32'(seg2), 0);
      check("rst2_busy", 32'(busy), 0);
      reset = 1'b0;
      tick();
      check("busy_after_rst", 32'(busy), 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
